mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3: number of requesters sharing the memory port.
REQ-002 The block SHALL have parameter ADDR_W, default 18: word address width, matching the memory manager's starting_address.
REQ-003 The block SHALL have parameter DATA_W, default 32: data word width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum number of WAIT cycles before abort.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
REQ-006 The block SHALL have these requester-side ports:
- req_valid  in  N_REQ  per-requester request
- req_wren  in  N_REQ  per-requester 1=write, 0=read
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data
- req_grant  out  N_REQ  one-hot; the current owner
- req_done  out  N_REQ  one-cycle completion pulse to the owner
- rd_data  out  DATA_W  read data, valid while req_done is high
REQ-007 The block SHALL have these memory-side ports:
- mem_cmd_valid  out  1  command present
- mem_cmd_ready  in  1  command accepted
- mem_wren  out  1  command type
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  command write data
- mem_done  in  1  single-cycle completion
- mem_rdata  in  DATA_W  read data, valid with mem_done
REQ-008 The block SHALL have these status ports:
- timeout_err  out  1  one-cycle pulse on abort
- err_sticky  out  1  set on abort, cleared only by reset
- busy  out  1  state != IDLE

Function
REQ-009 The block SHALL implement a state machine with states IDLE, ISSUE, WAIT and RELEASE.
REQ-010 IDLE: when any req_valid bit is high, the block SHALL select a winner round-robin, searching from (last_owner+1) mod N_REQ upward with wrap-around; it SHALL set req_grant one-hot and latch that requester's wren/addr/wdata into mem_wren/mem_addr/mem_wdata; next state is ISSUE.
REQ-011 When no req_valid bit is high in IDLE, the block SHALL remain in IDLE with req_grant=0.
REQ-012 ISSUE: mem_cmd_valid SHALL be 1; in any cycle where mem_cmd_ready=1, the command is accepted and the next state is WAIT.
REQ-013 mem_wren, mem_addr and mem_wdata SHALL stay stable from the latch until acceptance.
REQ-014 WAIT: mem_cmd_valid SHALL be 0 and a timeout counter SHALL increment each cycle.
REQ-015 WAIT: on mem_done=1, the block SHALL register mem_rdata into rd_data, pulse req_done[owner] for exactly one cycle, update last_owner, and go to RELEASE.
REQ-016 For writes, rd_data SHALL be loaded with the latched write data, giving pass-through on writes.
REQ-017 WAIT: when the counter reaches TIMEOUT_CYCLES with no mem_done, the block SHALL pulse timeout_err, set err_sticky, pulse req_done[owner] with rd_data=0, and go to RELEASE.
REQ-018 If mem_done and the timeout occur in the same cycle, mem_done SHALL take precedence and no error SHALL be raised.
REQ-019 RELEASE: req_grant SHALL be 0 and the next state is IDLE; this gives one mandatory bubble cycle, and the minimum transaction is 4 cycles with mem_cmd_ready and mem_done both immediate.
REQ-020 Once granted, a transaction SHALL complete even if the owner drops req_valid.
REQ-021 Changes on non-owner inputs SHALL be ignored until IDLE.
REQ-022 mem_done asserted outside WAIT SHALL be ignored and SHALL NOT pulse req_done.
REQ-023 After reset, last_owner SHALL equal N_REQ-1, so requester 0 wins first.
REQ-024 With all requesters continuously requesting, grants SHALL rotate 0,1,2,0,...; no requester waits more than N_REQ-1 transactions.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously force state=IDLE, req_grant=0, req_done=0, rd_data=0, mem_cmd_valid=0, mem_wren=0, mem_addr=0, mem_wdata=0, timeout_err=0, err_sticky=0, busy=0, counter=0, last_owner=N_REQ-1.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction without any req_done pulse.
REQ-027 Reset deassertion SHALL be synchronized externally; the block SHALL resume in IDLE.

Structure
REQ-028 The state encoding localparams and the WRITE/READ command-type constants SHALL live in the shared memory-interface package (mem_pkg) together with the default ADDR_W and DATA_W.
REQ-029 The round-robin winner selection SHALL be one combinational sub-module, rr_pick, with inputs request vector and last_owner and outputs a one-hot vector and an index.
REQ-030 The memory side SHALL connect directly to the memory manager's wren/address/data/pause handshake through a thin adapter outside this block.

Verification
REQ-031 Single read: req_valid=001, addr 0x00010; mem_cmd_ready=1 immediately; mem_done two cycles later with mem_rdata=0xA5A5_1234 -> req_done=001 for one cycle with rd_data=0xA5A5_1234; busy drops after RELEASE.
REQ-032 All three requesting continuously, 6 transactions -> grant order 0,1,2,0,1,2, one RELEASE bubble each.
REQ-033 mem_cmd_ready held low for 5 cycles in ISSUE while req_addr of the owner changes -> mem_addr is unchanged until acceptance.
REQ-034 mem_done withheld -> after TIMEOUT_CYCLES in WAIT: timeout_err pulse, err_sticky=1, req_done pulse with rd_data=0; the next request is still served.
REQ-035 rst_n pulled low during WAIT of a write to requester 1 -> all outputs zero immediately, no req_done; after release, requester 0 wins first.
REQ-036 mem_done coincident with the timeout cycle -> normal completion, timeout_err stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-interface definitions: default bus widths, command-type
// constants, arbiter state encoding and a small index-width helper.
package mem_pkg;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 32;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC   = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC    = 2'd2;
    localparam logic [1:0] ST_RELEASE_ENC = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE_ENC,
        S_ISSUE   = ST_ISSUE_ENC,
        S_WAIT    = ST_WAIT_ENC,
        S_RELEASE = ST_RELEASE_ENC
    } arb_state_e;

    // Width of an index able to address n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: searches upward from last_i+1 with
// wrap-around and returns the first requesting index, one-hot and binary.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found_s;
    int   cand_s;

    // Walk the N candidates starting after the previous owner; first hit wins.
    always_comb begin
        found_s  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        cand_s   = 0;
        for (int k = 1; k <= N; k++) begin
            cand_s = (int'(last_i) + k) % N;
            if (!found_s && req_i[cand_s]) begin
                found_s          = 1'b1;
                onehot_o[cand_s] = 1'b1;
                idx_o            = cand_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory command port between N_REQ
// requesters. One transaction at a time: IDLE -> ISSUE -> WAIT -> RELEASE,
// with a WAIT timeout that completes the owner with zero data and an error.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_wren,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_grant,
    output logic [N_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_wren,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_done,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      timeout_err,
    output logic                      err_sticky,
    output logic                      busy
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          state_q;
    logic [N_REQ-1:0]    grant_q;
    logic [N_REQ-1:0]    done_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                cmd_valid_q;
    logic                wren_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                tmo_q;
    logic                sticky_q;
    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    last_q;
    logic [IDX_W-1:0]    owner_q;

    logic [N_REQ-1:0]    pick_onehot_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                sel_wren_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (req_valid),
        .last_i   (last_q),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s)
    );

    assign sel_wren_s  = req_wren[pick_idx_s];
    assign sel_addr_s  = req_addr[pick_idx_s*ADDR_W +: ADDR_W];
    assign sel_wdata_s = req_wdata[pick_idx_s*DATA_W +: DATA_W];
    assign cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Arbitration FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            rd_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            wren_q      <= CMD_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            tmo_q       <= 1'b0;
            sticky_q    <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            last_q      <= LAST_RST;
            owner_q     <= '0;
        end else begin
            done_q <= '0;
            tmo_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req_valid) begin
                        // Command fields are frozen here until the memory accepts.
                        grant_q     <= pick_onehot_s;
                        owner_q     <= pick_idx_s;
                        wren_q      <= sel_wren_s;
                        addr_q      <= sel_addr_s;
                        wdata_q     <= sel_wdata_s;
                        cmd_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (mem_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_WAIT;
                    end else begin
                        cmd_valid_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // mem_done is checked first so a completion on the
                    // timeout cycle still counts as a normal completion.
                    if (mem_done) begin
                        rd_data_q <= (wren_q == CMD_WRITE) ? wdata_q : mem_rdata;
                        done_q    <= grant_q;
                        last_q    <= owner_q;
                        grant_q   <= '0;
                        state_q   <= S_RELEASE;
                    end else if (cnt_q == CNT_LIMIT) begin
                        // Abort also advances the rotation so a dead
                        // requester cannot starve the others.
                        rd_data_q <= '0;
                        done_q    <= grant_q;
                        tmo_q     <= 1'b1;
                        sticky_q  <= 1'b1;
                        last_q    <= owner_q;
                        grant_q   <= '0;
                        state_q   <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RELEASE: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant_q     <= '0;
                    cmd_valid_q <= 1'b0;
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_grant     = grant_q;
    assign req_done      = done_q;
    assign rd_data       = rd_data_q;
    assign mem_cmd_valid = cmd_valid_q;
    assign mem_wren      = wren_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign timeout_err   = tmo_q;
    assign err_sticky    = sticky_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory commands
// and completions into queues; a monitor pops and compares them whenever the
// DUT fires a command or pulses req_done.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int N   = 3;
    localparam int AW  = 18;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_wren, req_grant, req_done;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rd_data;
    logic            mem_cmd_valid, mem_cmd_ready, mem_wren, mem_done;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            timeout_err, err_sticky, busy;

    typedef struct {
        logic [N-1:0]  grant;
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic [N-1:0]  done;
        logic [DW-1:0] rd;
        logic          tmo;
    } done_t;

    cmd_t  cmd_q[$];
    done_t done_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // responder controls
    int            rsp_ready_hold = 0;
    int            rsp_done_dly   = 0;
    logic          rsp_withhold   = 1'b0;
    logic [DW-1:0] rsp_rdata      = '0;
    logic          fire_seen      = 1'b0;

    mem_arbiter #(
        .N_REQ          (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_wren      (req_wren),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_grant     (req_grant),
        .req_done      (req_done),
        .rd_data       (rd_data),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_wren      (mem_wren),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata),
        .timeout_err   (timeout_err),
        .err_sticky    (err_sticky),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wren[idx]           = w;
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = d;
    endtask

    task automatic push_cmd(input logic [N-1:0] g, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.grant = g; c.wren = w; c.addr = a; c.wdata = d;
        cmd_q.push_back(c);
    endtask

    task automatic push_done(input logic [N-1:0] g, input logic [DW-1:0] rd, input logic t);
        done_t e;
        e.done = g; e.rd = rd; e.tmo = t;
        done_q.push_back(e);
    endtask

    // Waits for a req_done pulse; n counts the negedges seen, including the pulse.
    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_done == '0 && n < max);
        if (req_done == '0)
            flag("done_wait", $sformatf("no req_done within %0d cycles, required a pulse", max));
    endtask

    task automatic check_idle(input string p);
        check({p, "_grant"},   64'(req_grant),     64'd0);
        check({p, "_done"},    64'(req_done),      64'd0);
        check({p, "_rd_data"}, 64'(rd_data),       64'd0);
        check({p, "_cmd_vld"}, 64'(mem_cmd_valid), 64'd0);
        check({p, "_wren"},    64'(mem_wren),      64'd0);
        check({p, "_addr"},    64'(mem_addr),      64'd0);
        check({p, "_wdata"},   64'(mem_wdata),     64'd0);
        check({p, "_tmo"},     64'(timeout_err),   64'd0);
        check({p, "_sticky"},  64'(err_sticky),    64'd0);
        check({p, "_busy"},    64'(busy),          64'd0);
    endtask

    // Memory model: holds ready low rsp_ready_hold cycles, then returns
    // mem_done rsp_done_dly cycles after acceptance unless withheld.
    initial begin : responder
        int wcnt;
        int hcnt;
        wcnt = -1;
        hcnt = 0;
        mem_cmd_ready = 1'b0;
        mem_done      = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_cmd_ready = 1'b0;
            mem_done      = 1'b0;
            mem_rdata     = '0;
            if (!rst_n) begin
                wcnt = -1;
                hcnt = 0;
            end else begin
                if (fire_seen) begin
                    wcnt = rsp_withhold ? -1 : rsp_done_dly;
                    hcnt = 0;
                end
                if (wcnt == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = rsp_rdata;
                    wcnt      = -1;
                end else if (wcnt > 0) begin
                    wcnt--;
                end
                if (mem_cmd_valid && !fire_seen) begin
                    if (hcnt >= rsp_ready_hold) mem_cmd_ready = 1'b1;
                    else hcnt++;
                end
            end
        end
    end

    // Monitor: compares accepted commands and completions against the queues.
    initial begin : monitor
        cmd_t  c;
        done_t e;
        forever begin
            @(negedge clk);
            fire_seen = mem_cmd_valid && mem_cmd_ready;
            if (fire_seen) begin
                if (cmd_q.size() == 0) begin
                    flag("cmd_unexpected", $sformatf("command addr %0h fired, required none", mem_addr));
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_grant", 64'(req_grant), 64'(c.grant));
                    check("cmd_wren",  64'(mem_wren),  64'(c.wren));
                    check("cmd_addr",  64'(mem_addr),  64'(c.addr));
                    check("cmd_wdata", 64'(mem_wdata), 64'(c.wdata));
                end
            end
            if (req_done != '0) begin
                if (done_q.size() == 0) begin
                    flag("done_unexpected", $sformatf("req_done=%b, required none", req_done));
                end else begin
                    e = done_q.pop_front();
                    check("done_vec", 64'(req_done),    64'(e.done));
                    check("rd_data",  64'(rd_data),     64'(e.rd));
                    check("done_tmo", 64'(timeout_err), 64'(e.tmo));
                end
            end else if (timeout_err) begin
                flag("tmo_stray", "timeout_err=1 without req_done, required 0");
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_wren  = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_last_pick", 64'(req_grant), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single read from requester 0, done one WAIT cycle after acceptance.
        rsp_ready_hold = 0; rsp_done_dly = 1; rsp_withhold = 1'b0;
        rsp_rdata = 32'hA5A5_1234;
        set_req(0, 1'b0, 18'h00010, 32'h0000_0000);
        push_cmd(3'b001, 1'b0, 18'h00010, 32'h0000_0000);
        push_done(3'b001, 32'hA5A5_1234, 1'b0);
        req_valid = 3'b001;
        wait_done(20, n);
        check("t1_latency", 64'(n), 64'd5);
        tick();
        req_valid = 3'b000;
        @(negedge clk);
        check("t1_done_one_cycle", 64'(req_done), 64'd0);
        check("t1_busy_drop", 64'(busy), 64'd0);

        // Fresh reset, then all three requesting continuously for six grants.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp_done_dly = 0;
        rsp_rdata = 32'h5555_AAAA;
        set_req(0, 1'b0, 18'h00100, 32'h0000_0000);
        set_req(1, 1'b1, 18'h00101, 32'hD000_0001);
        set_req(2, 1'b0, 18'h00102, 32'h0000_0000);
        for (int r = 0; r < 2; r++) begin
            push_cmd(3'b001, 1'b0, 18'h00100, 32'h0000_0000);
            push_done(3'b001, 32'h5555_AAAA, 1'b0);
            push_cmd(3'b010, 1'b1, 18'h00101, 32'hD000_0001);
            push_done(3'b010, 32'hD000_0001, 1'b0);
            push_cmd(3'b100, 1'b0, 18'h00102, 32'h0000_0000);
            push_done(3'b100, 32'h5555_AAAA, 1'b0);
        end
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_done(20, n);
            check("t2_spacing", 64'(n), 64'd4);
        end
        tick();
        req_valid = 3'b000;

        // Ready held low 5 cycles while the owner's address wiggles and the
        // owner drops its request; requester 0 joins and is served next.
        rsp_ready_hold = 5;
        rsp_rdata = 32'h600D_F00D;
        set_req(2, 1'b1, 18'h3FFFF, 32'hCAFE_F00D);
        set_req(0, 1'b0, 18'h00ABC, 32'h0000_0000);
        push_cmd(3'b100, 1'b1, 18'h3FFFF, 32'hCAFE_F00D);
        push_done(3'b100, 32'hCAFE_F00D, 1'b0);
        push_cmd(3'b001, 1'b0, 18'h00ABC, 32'h0000_0000);
        push_done(3'b001, 32'h600D_F00D, 1'b0);
        req_valid = 3'b100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_grant == '0 && n < 10);
        check("t3_grant", 64'(req_grant), 64'b100);
        for (int i = 0; i < 5; i++) begin
            tick();
            req_addr[2*AW +: AW] = 18'(i * 18'h01111);
            req_valid = 3'b001;
            @(negedge clk);
            check("t3_addr_hold", 64'(mem_addr), 64'h3FFFF);
            check("t3_grant_hold", 64'(req_grant), 64'b100);
        end
        wait_done(20, n);
        wait_done(20, n);
        tick();
        req_valid = 3'b000;
        rsp_ready_hold = 0;

        // Withheld mem_done: timeout abort, then a normal request still works.
        rsp_withhold = 1'b1;
        set_req(1, 1'b0, 18'h00020, 32'h0000_0000);
        push_cmd(3'b010, 1'b0, 18'h00020, 32'h0000_0000);
        push_done(3'b010, 32'h0000_0000, 1'b1);
        req_valid = 3'b010;
        wait_done(TMO + 10, n);
        check("t4_tmo_latency", 64'(n), 64'(TMO + 3));
        check("t4_sticky_set", 64'(err_sticky), 64'd1);
        tick();
        req_valid = 3'b000;
        @(negedge clk);
        check("t4_tmo_one_cycle", 64'(timeout_err), 64'd0);
        check("t4_sticky_hold", 64'(err_sticky), 64'd1);
        rsp_withhold = 1'b0;
        rsp_rdata = 32'h7777_8888;
        set_req(0, 1'b0, 18'h00030, 32'h0000_0000);
        push_cmd(3'b001, 1'b0, 18'h00030, 32'h0000_0000);
        push_done(3'b001, 32'h7777_8888, 1'b0);
        tick();
        req_valid = 3'b001;
        wait_done(20, n);
        check("t4_next_served", 64'(n), 64'd4);
        tick();
        req_valid = 3'b000;

        // mem_done on exactly the timeout cycle wins over the abort.
        rsp_done_dly = TMO - 1;
        rsp_rdata = 32'h0BAD_BEEF;
        set_req(2, 1'b0, 18'h00040, 32'h0000_0000);
        push_cmd(3'b100, 1'b0, 18'h00040, 32'h0000_0000);
        push_done(3'b100, 32'h0BAD_BEEF, 1'b0);
        req_valid = 3'b100;
        wait_done(TMO + 10, n);
        check("t5_coincident", 64'(n), 64'(TMO + 3));
        tick();
        req_valid = 3'b000;

        // mem_done one cycle late: abort, and the late pulse lands in RELEASE.
        rsp_done_dly = TMO;
        rsp_rdata = 32'h1357_9BDF;
        set_req(0, 1'b0, 18'h00050, 32'h0000_0000);
        push_cmd(3'b001, 1'b0, 18'h00050, 32'h0000_0000);
        push_done(3'b001, 32'h0000_0000, 1'b1);
        tick();
        req_valid = 3'b001;
        wait_done(TMO + 10, n);
        check("t5_late_tmo", 64'(n), 64'(TMO + 3));
        tick();
        req_valid = 3'b000;
        @(negedge clk);
        check("t5_late_done_ignored", 64'(req_done), 64'd0);

        // Reset in WAIT of a write by requester 1; requester 0 wins afterwards.
        rsp_withhold = 1'b1;
        rsp_done_dly = 0;
        set_req(1, 1'b1, 18'h01234, 32'h1111_2222);
        push_cmd(3'b010, 1'b1, 18'h01234, 32'h1111_2222);
        tick();
        req_valid = 3'b010;
        repeat (5) @(negedge clk);
        check("t6_busy_pre", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t6_rst");
        req_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_withhold = 1'b0;
        rsp_rdata = 32'h2468_ACE0;
        set_req(0, 1'b0, 18'h00060, 32'h0000_0000);
        set_req(2, 1'b0, 18'h00070, 32'h0000_0000);
        push_cmd(3'b001, 1'b0, 18'h00060, 32'h0000_0000);
        push_done(3'b001, 32'h2468_ACE0, 1'b0);
        tick();
        req_valid = 3'b111;
        wait_done(20, n);
        check("t6_after_reset", 64'(n), 64'd4);
        tick();
        req_valid = 3'b000;

        repeat (5) @(negedge clk);
        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        check("done_q_drained", 64'(done_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
